// File: rtl/mood_step_regulator.sv
// Merges per-source inc/dec requests into a saturating signed backlog and drains it
// as rate-limited one-cycle level step pulses; a stimulus override bypasses both.
module mood_step_regulator #(
  parameter int N_SRC      = 4,
  parameter int LEVEL_W    = 4,
  parameter int LEVEL_INIT = 8,
  parameter int ACC_W      = 3,
  parameter int COOLDOWN   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [N_SRC-1:0]   src_inc,
  input  logic [N_SRC-1:0]   src_dec,
  input  logic               override_inc,
  input  logic               override_dec,
  output logic               level_inc,
  output logic               level_dec,
  output logic [LEVEL_W-1:0] level,
  output logic               busy
);

  localparam int SUM_W = ACC_W + $clog2(N_SRC) + 1;
  localparam int CD_W  = (COOLDOWN > 1) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic signed [SUM_W-1:0] ONE     = SUM_W'(1);
  localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'((2 ** (ACC_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] ACC_MIN = -ACC_MAX;

  typedef enum logic {IDLE, COOL} state_t;

  state_t                    state, state_next;
  logic [CD_W-1:0]           cnt, cnt_next;
  logic signed [ACC_W-1:0]   backlog, backlog_next;
  logic [LEVEL_W-1:0]        level_next;
  logic                      emit_inc, emit_dec;
  logic signed [SUM_W-1:0]   net, sum, bl_ext;
  logic                      ovr_valid, bl_pos, bl_neg, lvl_max, lvl_min;

  assign ovr_valid = en & (override_inc ^ override_dec);
  assign bl_neg    = backlog[ACC_W-1];
  assign bl_pos    = ~backlog[ACC_W-1] & (|backlog);
  assign lvl_max   = (level == {LEVEL_W{1'b1}});
  assign lvl_min   = (level == '0);
  assign bl_ext    = {{(SUM_W-ACC_W){backlog[ACC_W-1]}}, backlog};
  assign busy      = (state == COOL) | (|backlog);

  // A source asserting inc and dec together cancels itself out.
  always_comb begin
    net = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (src_inc[i] && !src_dec[i])      net = net + ONE;
      else if (src_dec[i] && !src_inc[i]) net = net - ONE;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    backlog_next = backlog;
    emit_inc     = 1'b0;
    emit_dec     = 1'b0;
    sum          = bl_ext;

    // Cooldown runs regardless of enable; the last count hands back to IDLE.
    if (state == COOL) begin
      if (cnt <= CD_W'(1)) begin
        state_next = IDLE;
        cnt_next   = '0;
      end else begin
        cnt_next = cnt - CD_W'(1);
      end
    end

    if (ovr_valid) begin
      backlog_next = '0;
      emit_inc     = override_inc & ~lvl_max;
      emit_dec     = override_dec & ~lvl_min;
    end else if (en) begin
      if ((bl_pos && lvl_max) || (bl_neg && lvl_min)) begin
        // Requests pushing past the level limit are discarded.
        backlog_next = '0;
      end else begin
        if (state == IDLE) begin
          emit_inc = bl_pos;
          emit_dec = bl_neg;
        end
        sum = bl_ext + net;
        if (emit_inc) sum = sum - ONE;
        if (emit_dec) sum = sum + ONE;
        if (sum > ACC_MAX)      backlog_next = ACC_MAX[ACC_W-1:0];
        else if (sum < ACC_MIN) backlog_next = ACC_MIN[ACC_W-1:0];
        else                    backlog_next = sum[ACC_W-1:0];
      end
    end

    if ((emit_inc || emit_dec) && (COOLDOWN > 0)) begin
      state_next = COOL;
      cnt_next   = CD_W'(COOLDOWN);
    end

    level_next = level;
    if (emit_inc)      level_next = level + LEVEL_W'(1);
    else if (emit_dec) level_next = level - LEVEL_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      backlog   <= '0;
      level     <= LEVEL_W'(LEVEL_INIT);
      level_inc <= 1'b0;
      level_dec <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      backlog   <= backlog_next;
      level     <= level_next;
      level_inc <= emit_inc;
      level_dec <= emit_dec;
    end
  end

endmodule

// File: tb/tb_mood_step_regulator.sv
// Bench for mood_step_regulator: directed scenarios plus biased random traffic,
// all compared against an edge-level behavioural model of the regulator.
module tb_mood_step_regulator;

  localparam int N_SRC      = 4;
  localparam int LEVEL_W    = 4;
  localparam int LEVEL_INIT = 8;
  localparam int ACC_W      = 3;
  localparam int COOLDOWN   = 2;
  localparam int BL_MAX     = 3;
  localparam int LVL_MAX    = 15;

  logic               clk;
  logic               rst_n;
  logic               en;
  logic [N_SRC-1:0]   src_inc;
  logic [N_SRC-1:0]   src_dec;
  logic               override_inc;
  logic               override_dec;
  logic               level_inc;
  logic               level_dec;
  logic [LEVEL_W-1:0] level;
  logic               busy;

  mood_step_regulator #(
    .N_SRC(N_SRC), .LEVEL_W(LEVEL_W), .LEVEL_INIT(LEVEL_INIT),
    .ACC_W(ACC_W), .COOLDOWN(COOLDOWN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .src_inc(src_inc), .src_dec(src_dec),
    .override_inc(override_inc), .override_dec(override_dec),
    .level_inc(level_inc), .level_dec(level_dec),
    .level(level), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: signed backlog integer, level integer, and the edge index
  // of the most recent pulse, which gates when the next backlog pulse may occur.
  int m_bl, m_lvl, m_last, m_edge;
  bit m_inc, m_dec;
  logic [LEVEL_W-1:0] exp_q[$];

  function automatic void model_reset();
    m_bl   = 0;
    m_lvl  = LEVEL_INIT;
    m_last = -1000;
    m_edge = 0;
    m_inc  = 0;
    m_dec  = 0;
    exp_q.delete();
  endfunction

  function automatic void model_edge();
    int net;
    bit pulse_ok;
    m_edge++;
    m_inc = 0;
    m_dec = 0;
    if (en && (override_inc != override_dec)) begin
      m_bl = 0;
      if (override_inc && m_lvl < LVL_MAX) m_inc = 1;
      if (override_dec && m_lvl > 0)       m_dec = 1;
    end else if (en) begin
      net = 0;
      for (int i = 0; i < N_SRC; i++) begin
        if (src_inc[i] && !src_dec[i]) net = net + 1;
        if (src_dec[i] && !src_inc[i]) net = net - 1;
      end
      if ((m_bl > 0 && m_lvl == LVL_MAX) || (m_bl < 0 && m_lvl == 0)) begin
        m_bl = 0;
      end else begin
        pulse_ok = (m_edge >= m_last + COOLDOWN + 1);
        if (pulse_ok && m_bl > 0)      m_inc = 1;
        else if (pulse_ok && m_bl < 0) m_dec = 1;
        m_bl = m_bl + net - (m_inc ? 1 : 0) + (m_dec ? 1 : 0);
        if (m_bl > BL_MAX)  m_bl = BL_MAX;
        if (m_bl < -BL_MAX) m_bl = -BL_MAX;
      end
    end
    if (m_inc || m_dec) begin
      m_last = m_edge;
      m_lvl  = m_lvl + (m_inc ? 1 : 0) - (m_dec ? 1 : 0);
      exp_q.push_back(LEVEL_W'(m_lvl));
    end
  endfunction

  // One clock: advance the model with the inputs the DUT samples, then compare.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("level_inc", level_inc, m_inc);
    check("level_dec", level_dec, m_dec);
    check("level", level, m_lvl);
    check("busy", busy, ((m_edge < m_last + COOLDOWN) || (m_bl != 0)) ? 1 : 0);
    check("pulse_excl", level_inc & level_dec, 0);
    if (level_inc || level_dec) begin
      check("pulse_q_size_nonzero", (exp_q.size() > 0) ? 1 : 0, 1);
      if (exp_q.size() > 0) check("pulse_level", level, exp_q.pop_front());
    end
  endtask

  // driver tasks
  task automatic drive(input logic [N_SRC-1:0] si, input logic [N_SRC-1:0] sd,
                       input logic oi, input logic od, input logic e);
    src_inc      = si;
    src_dec      = sd;
    override_inc = oi;
    override_dec = od;
    en           = e;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_level_inc", level_inc, 0);
    check("rst_level_dec", level_dec, 0);
    check("rst_level", level, LEVEL_INIT);
    check("rst_busy", busy, 0);
    model_reset();
    src_inc = '0; src_dec = '0; override_inc = 0; override_dec = 0; en = 1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N_SRC-1:0] si, sd;
    logic oi, od, e;
    int inc_pct, dec_pct, roll;

    rst_n = 1'b0;
    en = 1'b1; src_inc = '0; src_dec = '0; override_inc = 0; override_dec = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("init_level", level, LEVEL_INIT);
    check("init_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single request: pulse two cycles later, level 8 -> 9
    drive(4'b0100, '0, 0, 0, 1);
    idle(6);
    check("t1_level", level, 9);

    // saturated backlog drains as three spaced pulses
    do_reset();
    drive(4'hF, '0, 0, 0, 1);
    idle(12);
    check("t2_level", level, 11);

    // cancelling requests
    do_reset();
    drive(4'b1001, 4'b1010, 0, 0, 1);
    idle(5);
    check("t3_level", level, 8);

    // override_dec while cooling with backlog at +3
    do_reset();
    drive(4'hF, '0, 0, 0, 1);
    drive(4'hF, '0, 0, 0, 1);
    drive('0, '0, 0, 1, 1);
    idle(8);
    check("t4_level", level, 8);

    // level limit: requests discarded, override_inc blocked
    do_reset();
    for (int i = 0; i < 7; i++) drive('0, '0, 1, 0, 1);
    drive(4'hF, '0, 0, 0, 1);
    idle(5);
    check("t5_level", level, 15);
    drive('0, '0, 1, 0, 1);
    idle(3);
    check("t5_ovr_level", level, 15);

    // reset during cooldown with backlog +2
    do_reset();
    drive(4'hF, '0, 0, 0, 1);
    idle(1);
    do_reset();
    idle(8);
    check("t6_level", level, 8);

    // biased random traffic
    inc_pct = 40; dec_pct = 10;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        inc_pct = $urandom_range(0, 60);
        dec_pct = $urandom_range(0, 60);
      end
      if (c % 1000 == 999) do_reset();
      for (int b = 0; b < N_SRC; b++) begin
        si[b] = ($urandom_range(0, 99) < inc_pct);
        sd[b] = ($urandom_range(0, 99) < dec_pct);
      end
      roll = $urandom_range(0, 19);
      oi = (roll == 0) || (roll == 2);
      od = (roll == 1) || (roll == 2);
      e  = ($urandom_range(0, 9) != 0);
      drive(si, sd, oi, od, e);
    end
    idle(10);
    check("pulse_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
